// File: rtl/alu_operand_issue_pkg.sv
// Shared definitions for the ID->EX operand issue stage: default widths,
// ALU opcode encodings and the EX-register bubble value.
package alu_operand_issue_pkg;

  localparam int unsigned ALU_DW = 32;
  localparam int unsigned ALU_RW = 5;
  localparam int unsigned ALU_OPW = 3;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_OR  = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_ILL = 3'b111
  } aluop_e;

  // Control half of the EX register; data fields are zeroed separately.
  typedef struct packed {
    logic               valid;
    logic               wreg;
    logic               m2reg;
    logic [ALU_OPW-1:0] aluop;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0, aluop: ALU_ADD};

endpackage

// File: rtl/alu_operand_issue_fwd_mux.sv
// One-operand forwarding selector. Picks the youngest in-flight producer of
// src_i (EX, then MEM, then WB) or falls back to the register-file value.
// Register index 0 never matches a producer.
// Ports: src_i/rf_val_i operand index and RF value; ex_*/mem_*/wb_* producer
// state; fwd_val_c forwarded operand (combinational).
module alu_operand_issue_fwd_mux #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic [DW-1:0] rf_val_i,
  input  logic          ex_valid_i,
  input  logic          ex_wreg_i,
  input  logic          ex_m2reg_i,
  input  logic [RW-1:0] ex_dst_i,
  input  logic [DW-1:0] ex_alu_output_i,
  input  logic          mem_wreg_i,
  input  logic          mem_m2reg_i,
  input  logic [RW-1:0] mem_dst_i,
  input  logic [DW-1:0] mem_alu_result_i,
  input  logic [DW-1:0] mem_load_data_i,
  input  logic          wb_wreg_i,
  input  logic [RW-1:0] wb_dst_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] fwd_val_c
);

  logic src_nz_c;
  logic ex_hit_c;
  logic mem_hit_c;
  logic wb_hit_c;

  assign src_nz_c  = (src_i != '0);
  // A load in EX has no data yet; the stall logic covers that case.
  assign ex_hit_c  = src_nz_c & ex_valid_i & ex_wreg_i & ~ex_m2reg_i & (ex_dst_i == src_i);
  assign mem_hit_c = src_nz_c & mem_wreg_i & (mem_dst_i == src_i);
  assign wb_hit_c  = src_nz_c & wb_wreg_i & (wb_dst_i == src_i);

  // Priority select, youngest producer first.
  always_comb begin
    fwd_val_c = rf_val_i;
    if (ex_hit_c) begin
      fwd_val_c = ex_alu_output_i;
    end else if (mem_hit_c) begin
      fwd_val_c = mem_m2reg_i ? mem_load_data_i : mem_alu_result_i;
    end else if (wb_hit_c) begin
      fwd_val_c = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_issue.sv
// ID->EX pipeline register producing ALU operands and opcode. Forwards from
// EX/MEM/WB, stalls decode for one cycle on a load-use hazard, and inserts
// bubbles on stall, flush or no valid decode instruction.
// Ports: clk/clrn clock and async active-low reset; id_* decode instruction
// and id_ready handshake (combinational); flush kills the entering
// instruction; ex_alu_output/mem_*/wb_* forwarding sources; ex_* registered
// EX-stage outputs.
// Optional: define ALU_OP_CHECK_EN to turn opcode 111 into a bubble and add
// the sticky illegal_op output.
module alu_operand_issue
  import alu_operand_issue_pkg::*;
#(
  parameter int unsigned DW = ALU_DW,
  parameter int unsigned RW = ALU_RW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [2:0]    id_aluop,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_sa,
  input  logic          id_aluimm,
  input  logic          id_shift,
  input  logic [RW-1:0] id_dst,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          flush,
  input  logic [DW-1:0] ex_alu_output,
  input  logic [RW-1:0] mem_dst,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_load_data,
  input  logic [RW-1:0] wb_dst,
  input  logic          wb_wreg,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alua,
  output logic [DW-1:0] ex_alub,
  output logic [2:0]    ex_aluop,
  output logic [RW-1:0] ex_dst,
`ifdef ALU_OP_CHECK_EN
  output logic          illegal_op,
`endif
  output logic          ex_wreg,
  output logic          ex_m2reg
);

  ex_ctrl_t      ctrl_q, ctrl_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [DW-1:0] alua_q, alua_d;
  logic [DW-1:0] alub_q, alub_d;

  logic          uses_rs_c;
  logic          stall_c;
  logic          take_c;
  logic [DW-1:0] rs_fwd_c;
  logic [DW-1:0] rt_fwd_c;

  // Operand forwarding, one selector per source register.
  alu_operand_issue_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_i            (id_rs),
    .rf_val_i         (id_rs_val),
    .ex_valid_i       (ctrl_q.valid),
    .ex_wreg_i        (ctrl_q.wreg),
    .ex_m2reg_i       (ctrl_q.m2reg),
    .ex_dst_i         (dst_q),
    .ex_alu_output_i  (ex_alu_output),
    .mem_wreg_i       (mem_wreg),
    .mem_m2reg_i      (mem_m2reg),
    .mem_dst_i        (mem_dst),
    .mem_alu_result_i (mem_alu_result),
    .mem_load_data_i  (mem_load_data),
    .wb_wreg_i        (wb_wreg),
    .wb_dst_i         (wb_dst),
    .wb_data_i        (wb_data),
    .fwd_val_c        (rs_fwd_c)
  );

  alu_operand_issue_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_i            (id_rt),
    .rf_val_i         (id_rt_val),
    .ex_valid_i       (ctrl_q.valid),
    .ex_wreg_i        (ctrl_q.wreg),
    .ex_m2reg_i       (ctrl_q.m2reg),
    .ex_dst_i         (dst_q),
    .ex_alu_output_i  (ex_alu_output),
    .mem_wreg_i       (mem_wreg),
    .mem_m2reg_i      (mem_m2reg),
    .mem_dst_i        (mem_dst),
    .mem_alu_result_i (mem_alu_result),
    .mem_load_data_i  (mem_load_data),
    .wb_wreg_i        (wb_wreg),
    .wb_dst_i         (wb_dst),
    .wb_data_i        (wb_data),
    .fwd_val_c        (rt_fwd_c)
  );

  // Load-use hazard: the load in EX has no data until it reaches MEM.
  // rt is always treated as a source, even for immediate forms.
  assign uses_rs_c = ~id_shift;
  assign stall_c   = id_valid & ctrl_q.valid & ctrl_q.wreg & ctrl_q.m2reg & (dst_q != '0) &
                     ((uses_rs_c & (dst_q == id_rs)) | (dst_q == id_rt));
  assign id_ready  = ~stall_c;

`ifdef ALU_OP_CHECK_EN
  logic illegal_c;
  logic illegal_q, illegal_d;

  assign illegal_c  = id_valid & ~flush & ~stall_c & (id_aluop == ALU_ILL);
  assign take_c     = id_valid & ~flush & ~stall_c & ~illegal_c;
  assign illegal_d  = illegal_q | illegal_c;
  assign illegal_op = illegal_q;

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`else
  assign take_c = id_valid & ~flush & ~stall_c;
`endif

  // Next EX register contents: captured instruction or bubble.
  always_comb begin
    ctrl_d = EX_CTRL_BUBBLE;
    dst_d  = '0;
    alua_d = '0;
    alub_d = '0;
    if (take_c) begin
      ctrl_d.valid = 1'b1;
      ctrl_d.wreg  = id_wreg;
      ctrl_d.m2reg = id_m2reg;
      ctrl_d.aluop = id_aluop;
      dst_d        = id_dst;
      alua_d       = id_shift ? DW'(id_sa) : rs_fwd_c;
      alub_d       = id_aluimm ? id_imm : rt_fwd_c;
    end
  end

  // ID->EX pipeline register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      dst_q  <= '0;
      alua_q <= '0;
      alub_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dst_q  <= dst_d;
      alua_q <= alua_d;
      alub_q <= alub_d;
    end
  end

  assign ex_valid = ctrl_q.valid;
  assign ex_wreg  = ctrl_q.wreg;
  assign ex_m2reg = ctrl_q.m2reg;
  assign ex_aluop = ctrl_q.aluop;
  assign ex_dst   = dst_q;
  assign ex_alua  = alua_q;
  assign ex_alub  = alub_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: reset, issue, forwarding priority,
// load-use stall, shift operands, flush and the optional illegal-op check.
module tb_alu_operand_issue;

  logic        clk;
  logic        clrn;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_aluop;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_sa;
  logic        id_aluimm, id_shift;
  logic [4:0]  id_dst;
  logic        id_wreg, id_m2reg;
  logic        flush;
  logic [31:0] ex_alu_output;
  logic [4:0]  mem_dst;
  logic        mem_wreg, mem_m2reg;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [4:0]  wb_dst;
  logic        wb_wreg;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_alua, ex_alub;
  logic [2:0]  ex_aluop;
  logic [4:0]  ex_dst;
  logic        ex_wreg, ex_m2reg;
`ifdef ALU_OP_CHECK_EN
  logic        illegal_op;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  alu_operand_issue dut (
    .clk            (clk),
    .clrn           (clrn),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_aluop       (id_aluop),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_val      (id_rs_val),
    .id_rt_val      (id_rt_val),
    .id_imm         (id_imm),
    .id_sa          (id_sa),
    .id_aluimm      (id_aluimm),
    .id_shift       (id_shift),
    .id_dst         (id_dst),
    .id_wreg        (id_wreg),
    .id_m2reg       (id_m2reg),
    .flush          (flush),
    .ex_alu_output  (ex_alu_output),
    .mem_dst        (mem_dst),
    .mem_wreg       (mem_wreg),
    .mem_m2reg      (mem_m2reg),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .wb_dst         (wb_dst),
    .wb_wreg        (wb_wreg),
    .wb_data        (wb_data),
    .ex_valid       (ex_valid),
    .ex_alua        (ex_alua),
    .ex_alub        (ex_alub),
    .ex_aluop       (ex_aluop),
    .ex_dst         (ex_dst),
`ifdef ALU_OP_CHECK_EN
    .illegal_op     (illegal_op),
`endif
    .ex_wreg        (ex_wreg),
    .ex_m2reg       (ex_m2reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decode instruction (shift/imm flags cleared unless set after).
  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [31:0] rs_val,
                       input logic [4:0] rt, input logic [31:0] rt_val,
                       input logic [4:0] dst, input logic wreg, input logic m2reg);
    id_valid  = 1'b1;
    id_aluop  = op;
    id_rs     = rs;
    id_rs_val = rs_val;
    id_rt     = rt;
    id_rt_val = rt_val;
    id_dst    = dst;
    id_wreg   = wreg;
    id_m2reg  = m2reg;
    id_imm    = 32'h0;
    id_sa     = 5'd0;
    id_aluimm = 1'b0;
    id_shift  = 1'b0;
  endtask

  task automatic clear_mem_wb();
    mem_dst = '0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
    mem_alu_result = '0; mem_load_data = '0;
    wb_dst = '0; wb_wreg = 1'b0; wb_data = '0;
  endtask

  initial begin
    clrn = 1'b0;
    flush = 1'b0;
    ex_alu_output = '0;
    clear_mem_wb();
    issue(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_alua", ex_alua, 32'h0);
    @(negedge clk) clrn = 1'b1;
    tick();
    chk("idle_valid", 32'(ex_valid), 32'd0);

    // Basic issue: add r3 <- r1 + r2
    issue(3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 1'b0);
    #1 chk("add_ready", 32'(id_ready), 32'd1);
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_alua", ex_alua, 32'd5);
    chk("add_alub", ex_alub, 32'd7);
    chk("add_op", 32'(ex_aluop), 32'd0);
    chk("add_dst", 32'(ex_dst), 32'd3);

    // EX forwarding: sub r0 <- r3 - r2, r3 comes from EX
    ex_alu_output = 32'h10;
    issue(3'b110, 5'd3, 32'h99, 5'd2, 32'd7, 5'd0, 1'b1, 1'b0);
    #1 chk("exfwd_ready", 32'(id_ready), 32'd1);
    tick();
    chk("exfwd_alua", ex_alua, 32'h10);
    chk("exfwd_alub", ex_alub, 32'd7);
    chk("exfwd_op", 32'(ex_aluop), 32'd6);

    // EX holds a write to r0: reading r0 must keep the register value
    issue(3'b000, 5'd0, 32'h22, 5'd2, 32'd7, 5'd6, 1'b1, 1'b0);
    tick();
    chk("r0_alua", ex_alua, 32'h22);

    // lw r4 <- [r1 + 8]
    issue(3'b000, 5'd1, 32'h100, 5'd0, 32'h0, 5'd4, 1'b1, 1'b1);
    id_aluimm = 1'b1;
    id_imm = 32'd8;
    tick();
    chk("lw_m2reg", 32'(ex_m2reg), 32'd1);
    chk("lw_alua", ex_alua, 32'h100);
    chk("lw_alub", ex_alub, 32'd8);

    // or r4 <- r4 | 0xF : load-use stall for one cycle
    issue(3'b010, 5'd4, 32'h5555, 5'd0, 32'h0, 5'd4, 1'b1, 1'b0);
    id_aluimm = 1'b1;
    id_imm = 32'h0F;
    #1 chk("lu_stall", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_alua", ex_alua, 32'h0);
    chk("lu_bubble_wreg", 32'(ex_wreg), 32'd0);
    mem_dst = 5'd4; mem_wreg = 1'b1; mem_m2reg = 1'b1;
    mem_load_data = 32'hABCD; mem_alu_result = 32'h108;
    #1 chk("lu_ready", 32'(id_ready), 32'd1);
    tick();
    chk("lu_valid", 32'(ex_valid), 32'd1);
    chk("lu_alua", ex_alua, 32'hABCD);
    chk("lu_alub", ex_alub, 32'h0F);
    chk("lu_op", 32'(ex_aluop), 32'd2);

    // EX and MEM both write r4: EX wins
    ex_alu_output = 32'h1234;
    mem_m2reg = 1'b0;
    issue(3'b011, 5'd4, 32'h1, 5'd4, 32'h2, 5'd7, 1'b1, 1'b0);
    tick();
    chk("exmem_alua", ex_alua, 32'h1234);
    chk("exmem_alub", ex_alub, 32'h1234);
    clear_mem_wb();

    // srl r8 <- r2 >> 4, r2 from WB
    wb_dst = 5'd2; wb_wreg = 1'b1; wb_data = 32'h80;
    issue(3'b100, 5'd7, 32'h3, 5'd2, 32'h1, 5'd8, 1'b1, 1'b0);
    id_shift = 1'b1;
    id_sa = 5'd4;
    tick();
    chk("srl_alua", ex_alua, 32'd4);
    chk("srl_alub", ex_alub, 32'h80);
    chk("srl_op", 32'(ex_aluop), 32'd4);

    // MEM beats WB on r2
    mem_dst = 5'd2; mem_wreg = 1'b1; mem_alu_result = 32'h55;
    issue(3'b001, 5'd2, 32'h9, 5'd2, 32'h9, 5'd0, 1'b0, 1'b0);
    tick();
    chk("memwb_alua", ex_alua, 32'h55);
    chk("memwb_alub", ex_alub, 32'h55);
    clear_mem_wb();

    // Flush kills a valid add
    issue(3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_dst", 32'(ex_dst), 32'd0);
    flush = 1'b0;

    // Flush during a load-use stall
    issue(3'b000, 5'd1, 32'h200, 5'd0, 32'h0, 5'd9, 1'b1, 1'b1);
    tick();
    issue(3'b000, 5'd9, 32'h1, 5'd0, 32'h0, 5'd10, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("flstall_ready", 32'(id_ready), 32'd0);
    tick();
    chk("flstall_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;

    // Opcode 111
    issue(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd5, 1'b1, 1'b0);
    tick();
`ifdef ALU_OP_CHECK_EN
    chk("ill_valid", 32'(ex_valid), 32'd0);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    issue(3'b000, 5'd1, 32'h11, 5'd2, 32'h22, 5'd5, 1'b1, 1'b0);
    tick();
    chk("ill_sticky", 32'(illegal_op), 32'd1);
    chk("ill_next_valid", 32'(ex_valid), 32'd1);
`else
    chk("op7_valid", 32'(ex_valid), 32'd1);
    chk("op7_op", 32'(ex_aluop), 32'd7);
    chk("op7_alua", ex_alua, 32'h11);
`endif

    // Async reset mid-run with a valid instruction in EX
    issue(3'b101, 5'd1, 32'h33, 5'd2, 32'h44, 5'd12, 1'b1, 1'b1);
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_alua", ex_alua, 32'h0);
    chk("arst_alub", ex_alub, 32'h0);
    chk("arst_op", 32'(ex_aluop), 32'd0);
    chk("arst_dst", 32'(ex_dst), 32'd0);
    chk("arst_m2reg", 32'(ex_m2reg), 32'd0);
`ifdef ALU_OP_CHECK_EN
    chk("arst_ill", 32'(illegal_op), 32'd0);
`endif
    id_valid = 1'b0;
    @(negedge clk) clrn = 1'b1;
    tick();
    chk("post_rst_valid", 32'(ex_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- ID→EX pipeline register that produces the ALU's operand and opcode inputs (ex_alua, ex_alub, ex_aluop) each cycle.
- Sits between the decode stage and the EX-stage ALU.
- Performs operand forwarding from the EX, MEM and WB stages, detects load-use hazards and stalls decode.
- Inserts bubbles on stall or flush.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_ready  out  1  issue accepts the decode instruction this cycle.
- id_aluop  in  3  000 add, 001 and, 010 or, 011 xor, 100 srl (b>>a), 101 sll (b<<a), 110 sub.
- id_rs, id_rt  in  RW  source register indices.
- id_rs_val, id_rt_val  in  DW  register-file read values.
- id_imm  in  DW  extended immediate.
- id_sa  in  5  shift amount.
- id_aluimm  in  1  alub = immediate.
- id_shift  in  1  alua = zero-extended sa.
- id_dst  in  RW  destination register.
- id_wreg  in  1  instruction writes a register.
- id_m2reg  in  1  instruction is a load.
- flush  in  1  kill the instruction entering EX.
- ex_alu_output  in  DW  current EX-stage ALU result.
- mem_dst  in  RW  MEM-stage destination.
- mem_wreg, mem_m2reg  in  1  MEM-stage write / load flags.
- mem_alu_result, mem_load_data  in  DW  MEM-stage values.
- wb_dst  in  RW  WB-stage destination.
- wb_wreg  in  1  WB-stage write flag.
- wb_data  in  DW  WB-stage value.
- ex_valid  out  1  EX holds a valid instruction.
- ex_alua, ex_alub  out  DW  registered ALU operands.
- ex_aluop  out  3  registered ALU opcode.
- ex_dst  out  RW  registered destination.
- ex_wreg, ex_m2reg  out  1  registered write / load flags.

Behaviour:
- Reset: clrn low asynchronously clears every ex_* output to 0 (ex_aluop=000).
  - Reset mid-stall drops the held instruction; decode re-presents it.
- uses_rs = ~id_shift; uses_rt = 1.
  - Shift ops: alua = {27'b0, id_sa}, alub = forwarded rt.
  - Non-shift ops: alua = forwarded rs; alub = id_aluimm ? id_imm : forwarded rt.
- Forwarding, per source, highest priority first. Register index 0 never matches.
  1. EX: ex_valid & ex_wreg & ~ex_m2reg & ex_dst==src → ex_alu_output.
  2. MEM: mem_wreg & mem_dst==src → mem_m2reg ? mem_load_data : mem_alu_result.
  3. WB: wb_wreg & wb_dst==src → wb_data.
  4. Otherwise the register-file value.
- Load-use stall:
  - stall = id_valid & ex_valid & ex_wreg & ex_m2reg & ex_dst≠0 & ((uses_rs & ex_dst==id_rs) | (uses_rt & ex_dst==id_rt)).
  - id_ready = ~stall, combinational.
  - A stall lasts exactly one cycle: the load moves to MEM and is then forwarded.
- Register update each rising edge, in priority order:
  1. flush → bubble.
  2. stall → bubble.
  3. id_valid → capture.
  4. Otherwise → bubble.
- Bubble: ex_valid=0, ex_wreg=0, ex_m2reg=0, ex_dst=0, ex_alua=0, ex_alub=0, ex_aluop=000.
- Latency: one cycle from acceptance to ex_* outputs.
- Flush during a stall: bubble; id_ready still follows stall.
- Simultaneous EX and MEM match on the same index: EX wins (youngest producer).

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined: id_aluop==111 with id_valid and no flush/stall is captured as a bubble.
  - Adds output illegal_op (1 bit), sticky, set that cycle, cleared only by clrn.
- Undefined: 111 passes through unchanged; no illegal_op port.

Decomposition:
- Shared package: aluop encodings (ALU_ADD..ALU_SUB), the DW/RW defaults, the bubble constant.
- One natural sub-module, fwd_mux: combinational one-operand forwarding selector, instantiated twice (rs, rt).
- Stall logic and the register stay in the top.

Test Plan:
- Reset: clrn=0 mid-run → all ex_* =0 immediately; after release with id_valid=0 → ex_valid stays 0.
- Basic issue: add, rs_val=5, rt_val=7, no hazards → next cycle ex_alua=5, ex_alub=7, ex_aluop=000, ex_valid=1.
- EX forwarding: write r3 then sub using r3, ex_alu_output=0x10 → ex_alua=0x10, no stall. Same with r0 as destination → register value used.
- Load-use: lw r4 then or r4,r4,imm (id_aluimm=1) → id_ready=0 for one cycle, bubble in EX; next cycle ex_alua=mem_load_data=0xABCD.
- Shift: srl, sa=4, rt=r2 forwarded from WB=0x80 → ex_alua=4, ex_alub=0x80, ex_aluop=100.
- Flush + illegal op: flush=1 with valid add → bubble. With ALU_OP_CHECK_EN, aluop=111 → bubble and illegal_op=1 held until reset.
